// File: rtl/shared_reg_arbiter_pkg.sv
// shared_reg_arbiter_pkg: state encoding, default sizes and owner-width helper
package shared_reg_arbiter_pkg;
    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_REQ = 4;
    function automatic int clog2_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// shared_reg_arbiter_rr_pick: combinational round-robin picker
// ports: req (requests), rr_ptr (highest-priority index) -> winner (index), valid (any request)
module shared_reg_arbiter_rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [clog2_w(N_REQ)-1:0]   rr_ptr,
    output logic [clog2_w(N_REQ)-1:0]   winner,
    output logic                        valid
);
    localparam int PW = clog2_w(N_REQ);
    logic [PW-1:0] idx;
    // Scan from farthest to nearest so the first set bit at or after rr_ptr wins;
    // N_REQ is a power of two, so PW-bit truncation gives the wrap-around.
    always_comb begin
        winner = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = rr_ptr + PW'(k);
            if (req[idx]) winner = idx;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin owner sequencer for one shared sync-clear data register
// ports: CLK (falling-edge clock), synchro_clr_n (sync active-low reset), req/clr_req/wdata (per requester),
//        grant (one-hot owner), owner (current/last owner), busy (owning), Q (register contents)
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int N_REQ     = DEF_N_REQ,
    parameter int MAX_BURST = 4
) (
    input  logic                       CLK,
    input  logic                       synchro_clr_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           clr_req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           grant,
    output logic [clog2_w(N_REQ)-1:0]  owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           Q
);
    localparam int PW = clog2_w(N_REQ);
    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] winner;
    logic          valid;
    logic [3:0]    burst_cnt;
    shared_reg_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (winner),
        .valid  (valid)
    );
    always_ff @(negedge CLK) begin
        if (!synchro_clr_n) begin
            state     <= IDLE;
            Q         <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (valid) begin
                state     <= OWN;
                owner     <= winner;
                grant     <= N_REQ'(1) << winner;
                busy      <= 1'b1;
                burst_cnt <= '0;
            end
        end else begin
            if (req[owner]) begin
                Q         <= clr_req[owner] ? '0 : wdata[owner*WIDTH +: WIDTH];
                burst_cnt <= burst_cnt + 4'd1;
            end
            // Release on dropped request or final burst write; releaser gets lowest priority.
            if (!req[owner] || burst_cnt == 4'(MAX_BURST - 1)) begin
                state  <= IDLE;
                grant  <= '0;
                busy   <= 1'b0;
                rr_ptr <= owner + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;
    logic        CLK;
    logic        synchro_clr_n;
    logic [3:0]  req;
    logic [3:0]  clr_req;
    logic [31:0] wdata;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  Q;
    int          n_cmp;
    int          n_bad;
    int          ord [5];
    shared_reg_arbiter #(.WIDTH(8), .N_REQ(4), .MAX_BURST(4)) dut (
        .CLK           (CLK),
        .synchro_clr_n (synchro_clr_n),
        .req           (req),
        .clr_req       (clr_req),
        .wdata         (wdata),
        .grant         (grant),
        .owner         (owner),
        .busy          (busy),
        .Q             (Q)
    );
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask
    initial begin
        n_cmp = 0;
        n_bad = 0;
        synchro_clr_n = 1'b0;
        req = '0;
        clr_req = '0;
        wdata = '0;
        tick();
        tick();
        chk("rst_q", Q, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        // reset mid-burst
        synchro_clr_n = 1'b1;
        wdata[16 +: 8] = 8'hA5;
        req = 4'b0100;
        tick();
        chk("mb_grant", grant, 4'b0100);
        chk("mb_owner", owner, 2);
        chk("mb_arb_q", Q, 0);
        tick();
        chk("mb_w1", Q, 8'hA5);
        tick();
        chk("mb_w2", Q, 8'hA5);
        synchro_clr_n = 1'b0;
        tick();
        chk("mb_rst_q", Q, 0);
        chk("mb_rst_grant", grant, 0);
        chk("mb_rst_busy", busy, 0);
        synchro_clr_n = 1'b1;
        req = 4'b0101;
        tick();
        chk("mb_regrant0", grant, 4'b0001);
        req = 4'b0000;
        tick();
        chk("mb_release", grant, 0);
        // single requester, long request (rr_ptr now 1, wraps to 0)
        wdata[0 +: 8] = 8'd12;
        req = 4'b0001;
        tick();
        chk("sr_arb", grant, 4'b0001);
        chk("sr_arb_q", Q, 0);
        for (int w = 0; w < 3; w++) begin
            tick();
            chk("sr_grant", grant, 4'b0001);
            chk("sr_q", Q, 12);
        end
        tick();
        chk("sr_end_grant", grant, 0);
        chk("sr_end_busy", busy, 0);
        chk("sr_end_q", Q, 12);
        tick();
        chk("sr_regrant", grant, 4'b0001);
        req = 4'b0000;
        tick();
        chk("sr_drop", busy, 0);
        // round robin from a fresh pointer
        synchro_clr_n = 1'b0;
        tick();
        synchro_clr_n = 1'b1;
        for (int i = 0; i < 4; i++) wdata[i*8 +: 8] = 8'(16 + i);
        req = 4'b1111;
        ord = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_grant", grant, 32'(1) << ord[k]);
            chk("rr_owner", owner, ord[k]);
            for (int w = 0; w < 4; w++) begin
                tick();
                chk("rr_q", Q, 16 + ord[k]);
            end
            chk("rr_gap", grant, 0);
        end
        req = 4'b0000;
        // clear priority, owner 1 (rr_ptr=1), non-owner clear ignored
        wdata[8 +: 8] = 8'd63;
        req = 4'b0010;
        clr_req = 4'b1000;
        tick();
        chk("cl_grant", grant, 4'b0010);
        tick();
        chk("cl_w1", Q, 63);
        clr_req = 4'b1010;
        tick();
        chk("cl_w2", Q, 0);
        req = 4'b0000;
        clr_req = 4'b0000;
        tick();
        chk("cl_rel", busy, 0);
        // early release by owner 2 (rr_ptr=2)
        wdata[16 +: 8] = 8'd32;
        req = 4'b0100;
        tick();
        chk("er_grant", grant, 4'b0100);
        tick();
        chk("er_w1", Q, 32);
        req = 4'b0000;
        tick();
        chk("er_idle_busy", busy, 0);
        chk("er_idle_grant", grant, 0);
        chk("er_hold_q", Q, 32);
        req = 4'b0001;
        tick();
        chk("er_next0", grant, 4'b0001);
        req = 4'b0000;
        tick();
        // pointer wrap: set rr_ptr=3 via a grant to 2
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b1001;
        tick();
        chk("wr_grant3", grant, 4'b1000);
        chk("wr_owner3", owner, 3);
        req = 4'b0001;
        tick();
        chk("wr_rel3", grant, 0);
        tick();
        chk("wr_grant0", grant, 4'b0001);
        req = 4'b0000;
        tick();
        req = 4'b0011;
        tick();
        chk("wr_ptr1", grant, 4'b0010);
        req = 4'b0000;
        tick();
        tick();
        chk("idle_stay", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
